oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/oam_dma_ctrl_if.sv | 31 +++
 rtl/oam_dma_ctrl.sv | 93 +++++++++
 tb/tb_oam_dma_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle for the OAM DMA controller: CPU side, RAM side and OAM write port.
// master = the DMA controller; slave = the surrounding system (CPU, RAM, OAM).
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw_n;
  logic        cpu_cs_n;
  logic        cpu_rdy;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_rw_n;
  logic        ram_cs_n;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_busy;
  logic        dma_done;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_rw_n, cpu_cs_n, ram_rdata,
    output cpu_rdy, ram_addr, ram_wdata, ram_rw_n, ram_cs_n,
    output oam_addr, oam_wdata, oam_we, dma_busy, dma_done
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rw_n, cpu_cs_n, ram_rdata,
    input  cpu_rdy, ram_addr, ram_wdata, ram_rw_n, ram_cs_n,
    input  oam_addr, oam_wdata, oam_we, dma_busy, dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA: a CPU write to DMA_REG_ADDR stalls the CPU and copies
// XFER_LEN bytes from RAM page {page,00} into OAM, one read/write pair per byte.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int unsigned XFER_LEN     = 256
) (
  input logic            clk,
  input logic            rst_n,
  oam_dma_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

  state_t     state;
  logic [7:0] page;
  logic [8:0] idx;
  logic       par;
  logic [7:0] oam_addr_q;
  logic       oam_we_q;
  logic       dma_done_q;
  logic       trigger;

  assign trigger = !bus.cpu_cs_n && !bus.cpu_rw_n && (bus.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      page       <= '0;
      idx        <= '0;
      par        <= 1'b0;
      oam_addr_q <= '0;
      oam_we_q   <= 1'b0;
      dma_done_q <= 1'b0;
    end else begin
      par        <= ~par;
      oam_we_q   <= 1'b0;
      dma_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            page  <= bus.cpu_wdata;
            idx   <= '0;
            state <= HALT;
          end
        end
        HALT:  state <= par ? ALIGN : READ;
        ALIGN: state <= READ;
        READ: begin
          state      <= WRITE;
          oam_we_q   <= 1'b1;
          oam_addr_q <= idx[7:0];
        end
        WRITE: begin
          idx <= idx + 9'd1;
          if (idx < LAST_IDX) begin
            state <= READ;
          end else begin
            state      <= IDLE;
            dma_done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port is a transparent CPU pass-through in IDLE; the DMA owns it otherwise.
  always_comb begin
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_rw_n  = bus.cpu_rw_n;
    bus.ram_cs_n  = bus.cpu_cs_n;
    bus.cpu_rdy   = 1'b1;
    bus.dma_busy  = 1'b0;
    if (state != IDLE) begin
      bus.cpu_rdy   = 1'b0;
      bus.dma_busy  = 1'b1;
      bus.ram_addr  = {page, idx[7:0]};
      bus.ram_wdata = '0;
      bus.ram_rw_n  = 1'b1;
      bus.ram_cs_n  = !((state == READ) || (state == WRITE));
    end
  end

  // RAM data only becomes valid during WRITE, so the OAM data path cannot be registered.
  assign bus.oam_wdata = (state == WRITE) ? bus.ram_rdata : '0;
  assign bus.oam_addr  = oam_addr_q;
  assign bus.oam_we    = oam_we_q;
  assign bus.dma_done  = dma_done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a behavioural 64K RAM and a 256-byte OAM.
module tb_oam_dma_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl #(
    .DMA_REG_ADDR(16'h4014),
    .XFER_LEN(256)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Environment state, written only by the monitor process.
  logic [7:0] wmem [int];
  logic [7:0] oam [256];
  bit  tb_par;
  int  we_cnt, done_cnt, nodma_cs_cnt, zero_acc, busy_cnt, bad_rw, we_idle;

  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'hFFFF) return 8'hA5;
    return 8'(a[7:0] * 8'd3) ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    return pat(a);
  endfunction

  always @(posedge clk) begin
    tb_par <= rst_n ? ~tb_par : 1'b0;
    if (!bus.ram_cs_n) begin
      if (!bus.ram_rw_n) wmem[int'(bus.ram_addr)] = bus.ram_wdata;
      else bus.ram_rdata <= mem_rd(bus.ram_addr);
    end
    if (bus.oam_we) oam[bus.oam_addr] <= bus.oam_wdata;
    if (bus.oam_we) we_cnt++;
    if (bus.oam_we && !bus.dma_busy) we_idle++;
    if (bus.dma_done) done_cnt++;
    if (bus.dma_busy && bus.ram_cs_n) nodma_cs_cnt++;
    if (bus.dma_busy && !bus.ram_cs_n && bus.ram_addr == 16'h0000) zero_acc++;
    if (bus.dma_busy) busy_cnt++;
    if (bus.dma_busy && !bus.ram_rw_n) bad_rw++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_idle;
    bus.cpu_cs_n  = 1'b1;
    bus.cpu_rw_n  = 1'b1;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
  endtask

  // inj_kind: 0 none, 1 CPU write of 8'h03 to the DMA register, 2 reset pulse.
  task automatic run_dma(input logic [7:0] pg, input bit align, input int inj_at,
                         input int inj_kind, output int stall, output bit done_seen);
    for (int g = 0; g < 3 && tb_par != !align; g++) tick;
    bus.cpu_addr  = 16'h4014;
    bus.cpu_wdata = pg;
    bus.cpu_rw_n  = 1'b0;
    bus.cpu_cs_n  = 1'b0;
    tick;
    cpu_idle();
    stall = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (bus.cpu_rdy) begin
        done_seen = bus.dma_done;
        break;
      end
      stall++;
      if (stall == inj_at && inj_kind == 1) begin
        bus.cpu_addr  = 16'h4014;
        bus.cpu_wdata = 8'h03;
        bus.cpu_rw_n  = 1'b0;
        bus.cpu_cs_n  = 1'b0;
      end
      if (stall == inj_at && inj_kind == 2) rst_n = 1'b0;
      tick;
      cpu_idle();
      rst_n = 1'b1;
    end
  endtask

  int  stall, we0, done0, cs0, busy0, bad;
  bit  done_seen;

  initial begin
    cpu_idle();
    bus.cpu_addr = 16'h1234;
    rst_n = 1'b0;
    repeat (3) tick;
    check("rst_cpu_rdy",   bus.cpu_rdy,   1);
    check("rst_dma_busy",  bus.dma_busy,  0);
    check("rst_oam_we",    bus.oam_we,    0);
    check("rst_dma_done",  bus.dma_done,  0);
    check("rst_oam_addr",  bus.oam_addr,  0);
    check("rst_oam_wdata", bus.oam_wdata, 0);
    check("rst_ram_addr",  bus.ram_addr,  16'h1234);
    check("rst_ram_cs_n",  bus.ram_cs_n,  1);
    rst_n = 1'b1;
    cpu_idle();
    tick;

    // Page 02, par = 0 in HALT: no ALIGN cycle.
    we0 = we_cnt; done0 = done_cnt; cs0 = nodma_cs_cnt;
    run_dma(8'h02, 1'b0, 0, 0, stall, done_seen);
    check("p02_stall", stall, 513);
    check("p02_done_level", done_seen, 1);
    tick;
    check("p02_we_pulses", we_cnt - we0, 256);
    check("p02_done_pulses", done_cnt - done0, 1);
    check("p02_cs_high_cycles", nodma_cs_cnt - cs0, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (oam[i] !== pat(16'h0200 + 16'(i))) bad++;
    check("p02_oam_bad", bad, 0);
    check("p02_trig_passthru", mem_rd(16'h4014), 8'h02);

    // Page FF must not wrap into page 00.
    run_dma(8'hFF, 1'b0, 0, 0, stall, done_seen);
    check("pff_stall", stall, 513);
    tick;
    check("pff_oam255", oam[255], 8'hA5);
    check("pff_zero_access", zero_acc, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (oam[i] !== pat(16'hFF00 + 16'(i))) bad++;
    check("pff_oam_bad", bad, 0);

    // Re-trigger with page 03 at stall cycle 100 is ignored.
    we0 = we_cnt;
    run_dma(8'h02, 1'b0, 100, 1, stall, done_seen);
    check("retrig_stall", stall, 513);
    tick;
    check("retrig_we_pulses", we_cnt - we0, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (oam[i] !== pat(16'h0200 + 16'(i))) bad++;
    check("retrig_oam_bad", bad, 0);
    check("retrig_ram_4014", mem_rd(16'h4014), 8'h02);

    // par = 1 in HALT: one ALIGN cycle.
    we0 = we_cnt; done0 = done_cnt; cs0 = nodma_cs_cnt;
    run_dma(8'h02, 1'b1, 0, 0, stall, done_seen);
    check("align_stall", stall, 514);
    tick;
    check("align_cs_high_cycles", nodma_cs_cnt - cs0, 2);
    check("align_we_pulses", we_cnt - we0, 256);
    check("align_done_pulses", done_cnt - done0, 1);

    // Reset at stall cycle 300 (a READ cycle; 149 bytes already written).
    we0 = we_cnt; done0 = done_cnt;
    run_dma(8'h07, 1'b0, 300, 2, stall, done_seen);
    check("abort_stall", stall, 300);
    check("abort_done_level", done_seen, 0);
    check("abort_oam_we", bus.oam_we, 0);
    check("abort_busy", bus.dma_busy, 0);
    repeat (4) tick;
    check("abort_we_pulses", we_cnt - we0, 149);
    check("abort_done_pulses", done_cnt - done0, 0);

    // IDLE pass-through write then read back.
    busy0 = busy_cnt;
    bus.cpu_addr  = 16'h0010;
    bus.cpu_wdata = 8'h5A;
    bus.cpu_rw_n  = 1'b0;
    bus.cpu_cs_n  = 1'b0;
    #1;
    check("pt_ram_addr", bus.ram_addr, 16'h0010);
    check("pt_ram_wdata", bus.ram_wdata, 8'h5A);
    check("pt_ram_rw_n", bus.ram_rw_n, 0);
    check("pt_ram_cs_n", bus.ram_cs_n, 0);
    tick;
    bus.cpu_rw_n  = 1'b1;
    bus.cpu_wdata = 8'h00;
    tick;
    check("pt_read_back", bus.ram_rdata, 8'h5A);
    cpu_idle();
    tick;
    check("pt_busy_cycles", busy_cnt - busy0, 0);
    check("busy_ram_write", bad_rw, 0);
    check("oam_we_idle", we_idle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
